// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-time prediction metadata, matched against EX-resolved outcomes to drive
// the next-PC predictor update interface and raise a front-end redirect on a misprediction.
module bp_resolve_queue #(
    parameter int gh_width   = 14,
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [ADDR_WIDTH-1:0] push_npc,
    input  logic [2:0]            push_kind,
    input  logic                  push_choice,
    input  logic [1:0]            push_pdch,
    input  logic [gh_width-1:0]   push_bh_hashed,
    input  logic [gh_width-1:0]   push_hashed,
    input  logic                  ex_valid,
    input  logic [2:0]            ex_kind,
    input  logic [ADDR_WIDTH-1:0] ex_npc,
    input  logic                  ex_ras_hit,
    output logic                  empty,
    output logic                  update_en,
    output logic [2:0]            kind_ex,
    output logic [ADDR_WIDTH-1:0] npc_ex,
    output logic [gh_width-1:0]   pc_ex_bh_hashed,
    output logic [gh_width-1:0]   pc_ex_hashed,
    output logic                  choice_real,
    output logic [1:0]            choice_pdch_ex,
    output logic [ADDR_WIDTH-1:0] ret_pc_ex,
    output logic                  mis_pdc,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [2:0] KIND_RET = 3'd4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] npc;
        logic [2:0]            kind;
        logic                  choice;
        logic [1:0]            pdch;
        logic [gh_width-1:0]   bh_hashed;
        logic [gh_width-1:0]   hashed;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop, mispredict;

    assign push_ready = (count_q != FULL_CNT);
    assign empty      = (count_q == '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = ex_valid && !empty;
    assign head       = mem_q[rd_ptr_q];
    assign mispredict = do_pop && ((ex_npc != head.npc) || (ex_kind != head.kind));

    // A mispredict flushes everything younger than the head, including a same-cycle push.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch; blocking '=' is correct in combinational logic.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (mispredict) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the entry array carries no reset; the pointers and count alone decide which entries
    // are live, so clearing storage would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst && do_push && !mispredict) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc, npc: push_npc, kind: push_kind, choice: push_choice,
                                 pdch: push_pdch, bh_hashed: push_bh_hashed, hashed: push_hashed};
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            update_en       <= 1'b0;
            kind_ex         <= '0;
            npc_ex          <= '0;
            pc_ex_bh_hashed <= '0;
            pc_ex_hashed    <= '0;
            choice_real     <= 1'b0;
            choice_pdch_ex  <= '0;
            ret_pc_ex       <= '0;
            mis_pdc         <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            update_en <= do_pop;
            mis_pdc   <= mispredict;
            if (do_pop) begin
                kind_ex         <= ex_kind;
                npc_ex          <= ex_npc;
                pc_ex_bh_hashed <= head.bh_hashed;
                pc_ex_hashed    <= head.hashed;
                choice_real     <= (ex_kind == KIND_RET) ? ex_ras_hit : head.choice;
                choice_pdch_ex  <= head.pdch;
                ret_pc_ex       <= head.pc + ADDR_WIDTH'(1);
            end
            if (mispredict) redirect_pc <= ex_npc;
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: a behavioural queue model predicts each update,
// expected results go to a scoreboard when EX resolves and are compared after the clock edge.
module tb_bp_resolve_queue;

    localparam int GW = 14;
    localparam int AW = 30;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid, push_ready, push_choice;
    logic [AW-1:0] push_pc, push_npc;
    logic [2:0]    push_kind;
    logic [1:0]    push_pdch;
    logic [GW-1:0] push_bh_hashed, push_hashed;
    logic          ex_valid, ex_ras_hit;
    logic [2:0]    ex_kind;
    logic [AW-1:0] ex_npc;
    logic          empty, update_en, choice_real, mis_pdc;
    logic [2:0]    kind_ex;
    logic [AW-1:0] npc_ex, ret_pc_ex, redirect_pc;
    logic [GW-1:0] pc_ex_bh_hashed, pc_ex_hashed;
    logic [1:0]    choice_pdch_ex;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] npc;
        logic [2:0]    kind;
        logic          choice;
        logic [1:0]    pdch;
        logic [GW-1:0] bh;
        logic [GW-1:0] h;
    } ent_t;

    typedef struct packed {
        logic [2:0]    kind;
        logic [AW-1:0] npc;
        logic [GW-1:0] bh;
        logic [GW-1:0] h;
        logic          choice;
        logic [1:0]    pdch;
        logic [AW-1:0] ret_pc;
        logic          mis;
        logic [AW-1:0] redir;
    } res_t;

    ent_t model_q[$];
    res_t exp_q[$];
    res_t last;
    int   n_cmp = 0;
    int   n_err = 0;

    bp_resolve_queue #(.gh_width(GW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc), .push_npc(push_npc),
        .push_kind(push_kind), .push_choice(push_choice), .push_pdch(push_pdch),
        .push_bh_hashed(push_bh_hashed), .push_hashed(push_hashed),
        .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_npc(ex_npc), .ex_ras_hit(ex_ras_hit),
        .empty(empty), .update_en(update_en), .kind_ex(kind_ex), .npc_ex(npc_ex),
        .pc_ex_bh_hashed(pc_ex_bh_hashed), .pc_ex_hashed(pc_ex_hashed),
        .choice_real(choice_real), .choice_pdch_ex(choice_pdch_ex), .ret_pc_ex(ret_pc_ex),
        .mis_pdc(mis_pdc), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        push_valid = 1'b0; push_pc = '0; push_npc = '0; push_kind = '0; push_choice = 1'b0;
        push_pdch = '0; push_bh_hashed = '0; push_hashed = '0;
        ex_valid = 1'b0; ex_kind = '0; ex_npc = '0; ex_ras_hit = 1'b0;
    endtask

    task automatic set_push(input logic [AW-1:0] pc, input logic [AW-1:0] npc, input logic [2:0] kind,
                            input logic choice, input logic [1:0] pdch);
        push_valid = 1'b1; push_pc = pc; push_npc = npc; push_kind = kind;
        push_choice = choice; push_pdch = pdch;
        push_bh_hashed = pc[GW-1:0] ^ GW'(14'h2A5);
        push_hashed    = pc[GW+1:2];
    endtask

    task automatic set_pop(input logic [2:0] kind, input logic [AW-1:0] npc, input logic ras_hit);
        ex_valid = 1'b1; ex_kind = kind; ex_npc = npc; ex_ras_hit = ras_hit;
    endtask

    // One clock: predict from the model, advance, compare every output against the prediction.
    task automatic step();
        logic acc_push, do_pop, mis, exp_upd;
        ent_t hd;
        res_t r;
        exp_upd = 1'b0;
        mis     = 1'b0;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            last = '0;
        end else begin
            acc_push = push_valid && (model_q.size() < DP);
            do_pop   = ex_valid && (model_q.size() > 0);
            if (do_pop) begin
                hd       = model_q[0];
                mis      = (ex_npc != hd.npc) || (ex_kind != hd.kind);
                r.kind   = ex_kind;
                r.npc    = ex_npc;
                r.bh     = hd.bh;
                r.h      = hd.h;
                r.choice = (ex_kind == 3'd4) ? ex_ras_hit : hd.choice;
                r.pdch   = hd.pdch;
                r.ret_pc = hd.pc + AW'(1);
                r.mis    = mis;
                r.redir  = mis ? ex_npc : last.redir;
                exp_q.push_back(r);
                exp_upd  = 1'b1;
                if (mis) model_q.delete();
                else void'(model_q.pop_front());
            end
            if (acc_push && !mis)
                model_q.push_back('{pc: push_pc, npc: push_npc, kind: push_kind, choice: push_choice,
                                    pdch: push_pdch, bh: push_bh_hashed, h: push_hashed});
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) last = exp_q.pop_front();
        check("update_en",   update_en,       exp_upd);
        check("mis_pdc",     mis_pdc,         exp_upd && last.mis);
        check("kind_ex",     kind_ex,         last.kind);
        check("npc_ex",      npc_ex,          last.npc);
        check("bh_hashed",   pc_ex_bh_hashed, last.bh);
        check("hashed",      pc_ex_hashed,    last.h);
        check("choice_real", choice_real,     last.choice);
        check("pdch_ex",     choice_pdch_ex,  last.pdch);
        check("ret_pc_ex",   ret_pc_ex,       last.ret_pc);
        check("redirect_pc", redirect_pc,     last.redir);
        check("empty",       empty,           model_q.size() == 0);
        check("push_ready",  push_ready,      model_q.size() < DP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        last = '0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;

        // 1: idle after reset
        repeat (10) step();
        check("t1_empty", empty, 1'b1);
        check("t1_ready", push_ready, 1'b1);

        // 2: single correct prediction
        set_push(30'h100, 30'h102, 3'd0, 1'b0, 2'b01); step(); clear_in();
        set_pop(3'd0, 30'h102, 1'b0); step(); clear_in();
        check("t2_upd", update_en, 1'b1);
        check("t2_mis", mis_pdc, 1'b0);
        check("t2_ret", ret_pc_ex, 30'h101);
        check("t2_empty", empty, 1'b1);
        step();
        check("t2_pulse", update_en, 1'b0);

        // 3: fill, overfill, pop one, simultaneous push+pop at full, drain
        for (int i = 0; i < DP; i++) begin
            set_push(AW'(30'h400 + i * 4), AW'(30'h401 + i * 4), 3'd1, 1'b0, 2'(i)); step(); clear_in();
        end
        check("t3_full", push_ready, 1'b0);
        set_push(30'h7777, 30'h7778, 3'd1, 1'b0, 2'b11); step(); clear_in();
        set_pop(3'd1, 30'h401, 1'b0); step(); clear_in();
        check("t3_ready", push_ready, 1'b1);
        set_push(30'h500, 30'h501, 3'd0, 1'b0, 2'b00); step(); clear_in();
        set_push(30'h600, 30'h601, 3'd0, 1'b0, 2'b00);
        set_pop(3'd1, 30'h405, 1'b0); step(); clear_in();
        for (int i = 2; i < DP; i++) begin
            set_pop(3'd1, AW'(30'h401 + i * 4), 1'b0); step(); clear_in();
        end
        set_pop(3'd0, 30'h501, 1'b0); step(); clear_in();
        check("t3_drained", empty, 1'b1);

        // 4: mispredict flushes younger entries and drops a same-cycle push
        set_push(30'h1F0, 30'h200, 3'd1, 1'b0, 2'b00); step(); clear_in();
        set_push(30'h200, 30'h201, 3'd0, 1'b0, 2'b00); step(); clear_in();
        set_push(30'h201, 30'h202, 3'd0, 1'b0, 2'b00); step(); clear_in();
        set_push(30'h202, 30'h203, 3'd0, 1'b0, 2'b00);
        set_pop(3'd1, 30'h300, 1'b0); step(); clear_in();
        check("t4_mis", mis_pdc, 1'b1);
        check("t4_redir", redirect_pc, 30'h300);
        check("t4_empty", empty, 1'b1);
        set_pop(3'd0, 30'h201, 1'b0); step(); clear_in();
        check("t4_noupd", update_en, 1'b0);

        // 5: RET with RAS miss
        set_push(30'h800, 30'h900, 3'd4, 1'b1, 2'b10); step(); clear_in();
        set_pop(3'd4, 30'h900, 1'b0); step(); clear_in();
        check("t5_choice", choice_real, 1'b0);
        check("t5_pdch", choice_pdch_ex, 2'b10);

        // 6: reset with full queue and active push/pop, then pc wrap
        for (int i = 0; i < DP; i++) begin
            set_push(AW'(30'hA00 + i), AW'(30'hA01 + i), 3'd7, 1'b1, 2'b11); step(); clear_in();
        end
        set_push(30'hB00, 30'hB01, 3'd0, 1'b0, 2'b00);
        set_pop(3'd0, 30'h123, 1'b0);
        rst = 1'b1; step(); rst = 1'b0; clear_in();
        check("t6_ready", push_ready, 1'b1);
        check("t6_empty", empty, 1'b1);
        check("t6_kind", kind_ex, 3'd0);
        check("t6_pdch", choice_pdch_ex, 2'b00);
        set_push(30'h3FFFFFFF, 30'h10, 3'd6, 1'b0, 2'b01); step(); clear_in();
        set_pop(3'd6, 30'h10, 1'b0); step(); clear_in();
        check("t6_wrap", ret_pc_ex, 30'h0);

        // random traffic with occasional mispredicts and resets
        for (int i = 0; i < 400; i++) begin
            clear_in();
            if ($urandom_range(0, 1) == 1)
                set_push(AW'($urandom_range(0, 32'hFFFF)), AW'($urandom_range(0, 15)),
                         3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) != 0) begin
                if (model_q.size() > 0 && $urandom_range(0, 7) != 0)
                    set_pop(model_q[0].kind, model_q[0].npc, 1'($urandom_range(0, 1)));
                else
                    set_pop(3'($urandom_range(0, 7)), AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            rst = 1'b0;
        end
        clear_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
